rotation_sequencer: RTL and testbench

- Upstream stage of the 4-digit character-rotation display path.
- Latches a 4-character word (four 2-bit character codes) from the switches and drives it as a held word.
- Generates a 2-bit rotation select that steps automatically at a programmable rate, so the display mux/decoder stage rotates the word without manual select switches.
- Supports pause/run and direction control.

---
 rtl/rotation_sequencer.sv | 135 +++++++++++++
 tb/tb_rotation_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rotation_sequencer.sv
// Word latch and auto-stepping rotation select for the 4-digit character display.
// Optional single-step pushbutton in IDLE is compiled in when ROT_STEP_EN is defined.
module rotation_sequencer #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic       fr_CLK,
    input  logic       fr_RST,
    input  logic [7:0] fr_SW,
    input  logic       fr_LOAD,
    input  logic       fr_PAUSE,
    input  logic       fr_DIR,
    input  logic       fr_STEP,
    output logic [7:0] to_WORD,
    output logic [1:0] to_SEL,
    output logic       to_RUN,
    output logic       to_TICK
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_load_sync;
    logic [2:0]       r_pause_sync;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] w_presc_nxt;
    logic [7:0]       w_word_nxt;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       w_sel_adv;
    logic             w_tick_nxt;
    logic             w_load_ev;
    logic             w_pause_ev;
    logic             w_step_ev;
    logic             w_tick;

    // Bit 0/1 synchronize the pushbutton, bit 2 holds the previous level for edge detect
    always_ff @(posedge fr_CLK) begin
        if (fr_RST) begin
            r_load_sync  <= 3'b000;
            r_pause_sync <= 3'b000;
        end else begin
            r_load_sync  <= {r_load_sync[1:0], fr_LOAD};
            r_pause_sync <= {r_pause_sync[1:0], fr_PAUSE};
        end
    end

    assign w_load_ev  = r_load_sync[1] & ~r_load_sync[2];
    assign w_pause_ev = r_pause_sync[1] & ~r_pause_sync[2];

`ifdef ROT_STEP_EN
    logic [2:0] r_step_sync;

    always_ff @(posedge fr_CLK) begin
        if (fr_RST) begin
            r_step_sync <= 3'b000;
        end else begin
            r_step_sync <= {r_step_sync[1:0], fr_STEP};
        end
    end

    assign w_step_ev = r_step_sync[1] & ~r_step_sync[2];
`else
    logic w_step_unused;

    assign w_step_unused = fr_STEP;
    assign w_step_ev     = 1'b0;
`endif

    assign w_tick    = (r_state == ST_RUN) && (r_presc == CNT_W'(TICK_DIV - 1));
    assign w_sel_adv = fr_DIR ? (to_SEL - 2'd1) : (to_SEL + 2'd1);

    // Load outranks tick/step; pause toggles on the pre-edge state
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_word_nxt  = to_WORD;
        w_sel_nxt   = to_SEL;
        w_tick_nxt  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_load_ev) begin
                    w_word_nxt  = fr_SW;
                    w_sel_nxt   = 2'd0;
                    w_presc_nxt = '0;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    w_sel_nxt   = w_sel_adv;
                    w_tick_nxt  = 1'b1;
                end else begin
                    w_presc_nxt = r_presc + CNT_W'(1);
                end
                if (w_pause_ev) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (w_load_ev) begin
                    w_word_nxt  = fr_SW;
                    w_sel_nxt   = 2'd0;
                    w_presc_nxt = '0;
                end else if (w_step_ev) begin
                    w_sel_nxt  = w_sel_adv;
                    w_tick_nxt = 1'b1;
                end
                if (w_pause_ev) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge fr_CLK) begin
        if (fr_RST) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            to_WORD <= 8'h00;
            to_SEL  <= 2'd0;
            to_RUN  <= 1'b0;
            to_TICK <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            to_WORD <= w_word_nxt;
            to_SEL  <= w_sel_nxt;
            to_RUN  <= (w_state_nxt == ST_RUN);
            to_TICK <= w_tick_nxt;
        end
    end

endmodule

// File: tb/tb_rotation_sequencer.sv
// Bench for rotation_sequencer: directed vector table, hand-timed corner sequences and
// randomized buttons checked against an event-history reference model (TICK_DIV=4).
module tb_rotation_sequencer;

    localparam int unsigned TD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       load;
    logic       pause;
    logic       dir;
    logic       stp;
    logic [7:0] to_WORD;
    logic [1:0] to_SEL;
    logic       to_RUN;
    logic       to_TICK;

    int n_chk = 0;
    int n_err = 0;

    rotation_sequencer #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .fr_CLK  (clk),
        .fr_RST  (rst),
        .fr_SW   (sw),
        .fr_LOAD (load),
        .fr_PAUSE(pause),
        .fr_DIR  (dir),
        .fr_STEP (stp),
        .to_WORD (to_WORD),
        .to_SEL  (to_SEL),
        .to_RUN  (to_RUN),
        .to_TICK (to_TICK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: button levels seen at the last three edges; an event fires two
    // edges after the first edge that saw the button high.
    logic [7:0] m_word;
    int         m_sel;
    int         m_presc;
    bit         m_run;
    bit         m_tick;
    bit         hl[3];
    bit         hp[3];
    bit         hs[3];

    function automatic void model_edge();
        bit ld_ev;
        bit pz_ev;
        bit st_ev;
        bit tk;
        if (rst) begin
            m_word = 8'h00; m_sel = 0; m_presc = 0; m_run = 0; m_tick = 0;
            for (int i = 0; i < 3; i++) begin hl[i] = 0; hp[i] = 0; hs[i] = 0; end
            return;
        end
        ld_ev  = hl[1] && !hl[2];
        pz_ev  = hp[1] && !hp[2];
        st_ev  = hs[1] && !hs[2];
        tk     = m_run && (m_presc == TD - 1);
        m_tick = 0;
        if (ld_ev) begin
            m_word = sw; m_sel = 0; m_presc = 0;
        end else if (tk) begin
            m_presc = 0;
            m_sel   = dir ? (m_sel + 3) % 4 : (m_sel + 1) % 4;
            m_tick  = 1;
        end else if (m_run) begin
            m_presc = m_presc + 1;
        end
`ifdef ROT_STEP_EN
        else if (st_ev) begin
            m_sel  = dir ? (m_sel + 3) % 4 : (m_sel + 1) % 4;
            m_tick = 1;
        end
`else
        if (st_ev) m_tick = m_tick;
`endif
        if (pz_ev) m_run = !m_run;
        hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = load;
        hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = pause;
        hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = stp;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        cycle();
        chk("model_word", 32'(to_WORD), 32'(m_word));
        chk("model_sel",  32'(to_SEL),  32'(m_sel));
        chk("model_run",  32'(to_RUN),  32'(m_run));
        chk("model_tick", 32'(to_TICK), 32'(m_tick));
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            n++;
            if (to_TICK) break;
        end
        chk("tick_within_budget", 32'(to_TICK), 32'd1);
    endtask

    typedef struct {
        bit       rst;
        bit [7:0] sw;
        bit       load;
        bit       pause;
        bit       dir;
        bit [7:0] ew;
        bit [1:0] es;
        bit       er;
        bit       et;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        int chg;
        int tks;
        logic prev;

        rst = 1'b1; sw = 8'h00; load = 1'b0; pause = 1'b0; dir = 1'b0; stp = 1'b0;

        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'hE4, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'hE4, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'hE4, 1'b0, 1'b0, 1'b0, 8'hE4, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hE4, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hE4, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hE4, 2'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hE4, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hE4, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hE4, 2'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hE4, 2'd1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hE4, 2'd1, 1'b1, 1'b0};

        // Reset, load E4, start running, first tick
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; sw = tbl[i].sw; load = tbl[i].load;
            pause = tbl[i].pause; dir = tbl[i].dir;
            cycle();
            chk("tbl_word", 32'(to_WORD), 32'(tbl[i].ew));
            chk("tbl_sel",  32'(to_SEL),  32'(tbl[i].es));
            chk("tbl_run",  32'(to_RUN),  32'(tbl[i].er));
            chk("tbl_tick", 32'(to_TICK), 32'(tbl[i].et));
        end

        // Incrementing sequence 2,3,0,1 at a 4-cycle tick period
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            chk("inc_sel", 32'(to_SEL), 32'((i + 2) % 4));
            if (i > 0) chk("tick_period", 32'(n), 32'(TD));
        end

        // Direction reversal from 1: 0,3,2
        dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            chk("dec_sel", 32'(to_SEL), 32'((4 - i) % 4));
        end

        // Held pause toggles exactly once
        pause = 1'b1;
        chg = 0;
        prev = to_RUN;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) pause = 1'b0;
            step();
            if (to_RUN !== prev) chg++;
            prev = to_RUN;
        end
        chk("pause_hold_toggles", 32'(chg), 32'd1);
        chk("pause_hold_idle", 32'(to_RUN), 32'd0);

        pause = 1'b1; step(); pause = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rerun", 32'(to_RUN), 32'd1);

        // Load event lands on the tick edge
        dir = 1'b0;
        wait_tick(n);
        sw = 8'h1B;
        load = 1'b0; step();
        load = 1'b1; step(); step();
        load = 1'b0; step();
        chk("ld_tick_sel",  32'(to_SEL),  32'd0);
        chk("ld_tick_tick", 32'(to_TICK), 32'd0);
        chk("ld_tick_word", 32'(to_WORD), 32'h1B);
        tks = 0;
        for (int i = 0; i < 3; i++) begin step(); tks += int'(to_TICK); end
        chk("ld_no_early_tick", 32'(tks), 32'd0);
        step();
        chk("ld_restart_tick", 32'(to_TICK), 32'd1);
        chk("ld_restart_sel",  32'(to_SEL),  32'd1);

        // Reset mid-RUN at select 3
        for (int i = 0; i < 20 && to_SEL != 2'd3; i++) step();
        chk("pre_rst_sel", 32'(to_SEL), 32'd3);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_word", 32'(to_WORD), 32'd0);
        chk("rst_sel",  32'(to_SEL),  32'd0);
        chk("rst_run",  32'(to_RUN),  32'd0);
        chk("rst_tick", 32'(to_TICK), 32'd0);
        tks = 0;
        for (int i = 0; i < 20; i++) begin step(); tks += int'(to_TICK) + int'(to_SEL); end
        chk("idle_after_rst_quiet", 32'(tks), 32'd0);

`ifdef ROT_STEP_EN
        // Single step backwards from 0 in IDLE
        dir = 1'b1;
        stp = 1'b1; step(); stp = 1'b0;
        tks = 0;
        for (int i = 0; i < 4; i++) begin step(); tks += int'(to_TICK); end
        chk("step_ticks", 32'(tks), 32'd1);
        chk("step_sel", 32'(to_SEL), 32'd3);
        pause = 1'b1; step(); pause = 1'b0;
        for (int i = 0; i < 3; i++) step();
        stp = 1'b1; step(); stp = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1; step(); rst = 1'b0;
`endif

        // Randomized buttons, direction, switches and occasional reset
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 15) == 0) ? ~load : load;
            pause = ($urandom_range(0, 11) == 0) ? ~pause : pause;
            stp   = ($urandom_range(0, 5) == 0) ? ~stp : stp;
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            sw    = 8'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
